prt_vtb_tg: RTL and testbench
=============================

Name: prt_vtb_tg

Overview:
Video Toolbox timing generator. Produces the raster VS/HS/DE that clocks pixels out of the video toolbox FIFO. Starts and stops on the FIFO's timing-generator run output. Timing is programmable in clock units (one clock = P_PPC pixels). Sits directly upstream of the FIFO's VID_VS_IN/VID_HS_IN/VID_DE_IN.

Parameters:
P_PPC, 2, pixels per clock; informational only, all horizontal values are already in clocks
P_CNT, 16, width of timing config fields and counters

Ports:
VID_RST_IN  in  1  reset; asynchronous, active-high
VID_CLK_IN  in  1  clock
VID_CKE_IN  in  1  clock enable; counters and outputs advance only when high
CTL_RUN_IN  in  1  run, from FIFO timing-generator run output
CFG_HTOTAL_IN  in  P_CNT  clocks per line
CFG_HSW_IN  in  P_CNT  hsync width
CFG_HSTART_IN  in  P_CNT  first active clock in a line
CFG_HACT_IN  in  P_CNT  active clocks per line
CFG_VTOTAL_IN  in  P_CNT  lines per frame
CFG_VSW_IN  in  P_CNT  vsync width in lines
CFG_VSTART_IN  in  P_CNT  first active line
CFG_VACT_IN  in  P_CNT  active lines
VID_VS_OUT  out  1  vsync
VID_HS_OUT  out  1  hsync
VID_DE_OUT  out  1  data enable
VID_SOF_OUT  out  1  one-CKE pulse at first active pixel of frame
STA_RUN_OUT  out  1  generator running

Behaviour:
- Reset: all outputs 0; counters h=0, v=0; state IDLE.
- States: IDLE, RUN. Run is sampled into a register first (1-clock delay).
- IDLE -> RUN: on registered run=1 with CKE.
  - On entry, all CFG_* inputs are latched into shadow registers.
  - h=0, v=0.
- RUN -> IDLE: on registered run=0, regardless of CKE.
  - Next clock: all outputs 0, counters cleared.
  - Loss of run mid-line or mid-frame truncates the frame; no completion.
- Counting in RUN, per CKE:
  - h increments. At h=HTOTAL-1, h wraps to 0 and v increments.
  - At v=VTOTAL-1 with h wrap, v wraps to 0 and the shadow registers reload from CFG_*.
  - Config changes therefore take effect only at frame boundaries.
- Decode (from counter values; outputs registered, 1 CKE latency from counter state):
  - HS = (h < HSW).
  - VS = (v < VSW). VS edges align with h=0, so they are coincident with the HS rising edge.
  - DE = (HSTART <= h < HSTART+HACT) and (VSTART <= v < VSTART+VACT).
  - SOF = DE and h==HSTART and v==VSTART.
- Arithmetic: compares use P_CNT+1 bit sums, so HSTART+HACT never wraps.
- Windows past total are clipped at line/frame end; no wrap into the next line.
- Degenerate config:
  - HSW=0 or VSW=0: sync never asserted.
  - HACT=0 or VACT=0: DE never asserted, SOF never pulses.
  - HTOTAL or VTOTAL of 0 or 1 is treated as 1 (counter held at 0, v advances every clock).
- CKE low: counters and outputs hold.
- Reset mid-frame: immediate clear to reset values; restart requires run to be sampled high again.
- STA_RUN_OUT = state==RUN.

Optional Feature:
- Macro: PRT_VTB_TG_POL_EN.
- When defined:
  - Adds inputs CFG_HS_POL_IN and CFG_VS_POL_IN (1 bit each, latched into the shadow registers).
  - A value of 1 inverts the respective sync output while in RUN.
  - In IDLE and reset, each sync output drives its inactive level, i.e. equal to its polarity bit.
- When undefined: syncs are active-high only; the ports are absent.

Decomposition:
- Package prt_vtb_tg_pkg holds:
  - typedef tg_cfg_struct (all shadow fields);
  - enum sm_state {sm_idle, sm_run};
  - localparam P_CNT default.
- Sub-module prt_vtb_tg_axis contains one axis counter with wrap plus window compare: sync window [0,SW) and active window [START,START+ACT).
  - Instantiated twice: horizontal with step=CKE; vertical with step=CKE and h-wrap.

Test Plan:
1. Config HTOTAL=10, HSW=2, HSTART=3, HACT=4, VTOTAL=6, VSW=1, VSTART=2, VACT=3; CKE=1; run high -> per line HS high 2 clocks and DE high 4 clocks starting 3 clocks after HS rise; DE on lines 2-4 only; VS high for first 10 clocks of frame; frame period 60 clocks; SOF once per frame.
2. Same config, CKE toggling 1/0 -> all output durations exactly double; frame period 120 clocks; outputs stable while CKE=0.
3. Change HACT to 6 mid-frame -> current frame keeps DE width 4; next frame DE width 6, starting at the first clock after the v wrap.
4. Deassert run at h=5, v=3 -> two clocks later all outputs 0 and STA_RUN_OUT=0; reassert -> first output clock shows HS=1, VS=1 (h=0, v=0).
5. Assert VID_RST_IN mid-frame -> outputs 0 asynchronously; after release with run high, raster restarts at h=0, v=0.
6. HSTART=8, HACT=5, HTOTAL=10 -> DE high only at h=8,9 on active lines. VSW=0 -> VS never asserts.

Source files
------------

// File: rtl/prt_vtb_tg_pkg.sv
// Shared types for the video toolbox timing generator.
// The shadow register struct carries the polarity bits only when PRT_VTB_TG_POL_EN is defined.
package prt_vtb_tg_pkg;

    // Counter and config field width; the shadow struct is sized from this.
    localparam int P_CNT_DEF = 16;

    typedef enum logic {
        sm_idle,
        sm_run
    } sm_state;

    typedef struct packed {
        logic [P_CNT_DEF-1:0] htotal;
        logic [P_CNT_DEF-1:0] hsw;
        logic [P_CNT_DEF-1:0] hstart;
        logic [P_CNT_DEF-1:0] hact;
        logic [P_CNT_DEF-1:0] vtotal;
        logic [P_CNT_DEF-1:0] vsw;
        logic [P_CNT_DEF-1:0] vstart;
        logic [P_CNT_DEF-1:0] vact;
`ifdef PRT_VTB_TG_POL_EN
        logic                 hs_pol;
        logic                 vs_pol;
`endif
    } tg_cfg_struct;

endpackage

// File: rtl/prt_vtb_tg_axis.sv
// One raster axis: wrapping position counter plus sync and active window decode.
// A total of 0 or 1 behaves as 1, so the counter sits at 0 and wraps on every step.
module prt_vtb_tg_axis
    import prt_vtb_tg_pkg::*;
#(
    parameter int P_CNT = P_CNT_DEF
) (
    input  logic             reset,
    input  logic             clock,
    input  logic             clear,
    input  logic             step,
    input  logic [P_CNT-1:0] total,
    input  logic [P_CNT-1:0] sw,
    input  logic [P_CNT-1:0] start,
    input  logic [P_CNT-1:0] act,
    output logic             at_last,
    output logic             sync_hit,
    output logic             act_hit,
    output logic             start_hit
);

    logic [P_CNT-1:0] cnt;
    logic [P_CNT-1:0] last;
    logic [P_CNT:0]   act_end;

    // Window decode; the active end is one bit wider so START+ACT never wraps.
    always_comb begin
        last      = (total <= P_CNT'(1)) ? '0 : total - P_CNT'(1);
        at_last   = (cnt >= last);
        act_end   = {1'b0, start} + {1'b0, act};
        sync_hit  = (cnt < sw);
        act_hit   = (cnt >= start) && ({1'b0, cnt} < act_end);
        start_hit = (cnt == start);
    end

    // Position counter: cleared while not running, wraps to 0 after the last position.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= at_last ? '0 : cnt + P_CNT'(1);
        end
    end

endmodule

// File: rtl/prt_vtb_tg.sv
// Video toolbox timing generator: programmable VS/HS/DE/SOF raster gated by the FIFO run output.
// Optional macro PRT_VTB_TG_POL_EN adds per-sync polarity inputs.
module prt_vtb_tg
    import prt_vtb_tg_pkg::*;
#(
    parameter int P_PPC = 2,
    parameter int P_CNT = P_CNT_DEF
) (
    input  logic             VID_RST_IN,
    input  logic             VID_CLK_IN,
    input  logic             VID_CKE_IN,
    input  logic             CTL_RUN_IN,
    input  logic [P_CNT-1:0] CFG_HTOTAL_IN,
    input  logic [P_CNT-1:0] CFG_HSW_IN,
    input  logic [P_CNT-1:0] CFG_HSTART_IN,
    input  logic [P_CNT-1:0] CFG_HACT_IN,
    input  logic [P_CNT-1:0] CFG_VTOTAL_IN,
    input  logic [P_CNT-1:0] CFG_VSW_IN,
    input  logic [P_CNT-1:0] CFG_VSTART_IN,
    input  logic [P_CNT-1:0] CFG_VACT_IN,
`ifdef PRT_VTB_TG_POL_EN
    input  logic             CFG_HS_POL_IN,
    input  logic             CFG_VS_POL_IN,
`endif
    output logic             VID_VS_OUT,
    output logic             VID_HS_OUT,
    output logic             VID_DE_OUT,
    output logic             VID_SOF_OUT,
    output logic             STA_RUN_OUT
);

    // Pixels per clock is informational; horizontal config already arrives in clocks.
    if (P_PPC < 1) begin : g_ppc_unused
    end

    sm_state      state;
    sm_state      state_next;
    logic         run_reg;
    tg_cfg_struct cfg_in;
    tg_cfg_struct shadow;
    logic         enter;
    logic         running;
    logic         clear;
    logic         h_step;
    logic         v_step;
    logic         frame_end;
    logic         h_at_last, h_sync, h_act, h_start;
    logic         v_at_last, v_sync, v_act, v_start;
    logic         hs_act, vs_act, de_q, sof_q;

    // Gather the live config so it can be captured in one shot.
    always_comb begin
        cfg_in        = '0;
        cfg_in.htotal = CFG_HTOTAL_IN;
        cfg_in.hsw    = CFG_HSW_IN;
        cfg_in.hstart = CFG_HSTART_IN;
        cfg_in.hact   = CFG_HACT_IN;
        cfg_in.vtotal = CFG_VTOTAL_IN;
        cfg_in.vsw    = CFG_VSW_IN;
        cfg_in.vstart = CFG_VSTART_IN;
        cfg_in.vact   = CFG_VACT_IN;
`ifdef PRT_VTB_TG_POL_EN
        cfg_in.hs_pol = CFG_HS_POL_IN;
        cfg_in.vs_pol = CFG_VS_POL_IN;
`endif
    end

    // Register the run request before the state machine sees it.
    always_ff @(posedge VID_CLK_IN or posedge VID_RST_IN) begin
        if (VID_RST_IN) begin
            run_reg <= 1'b0;
        end else begin
            run_reg <= CTL_RUN_IN;
        end
    end

    // State register.
    always_ff @(posedge VID_CLK_IN or posedge VID_RST_IN) begin
        if (VID_RST_IN) begin
            state <= sm_idle;
        end else begin
            state <= state_next;
        end
    end

    // Start needs an enabled clock; stop is immediate regardless of the enable.
    always_comb begin
        state_next = state;
        case (state)
            sm_idle: if (run_reg && VID_CKE_IN) state_next = sm_run;
            sm_run:  if (!run_reg) state_next = sm_idle;
        endcase
    end

    assign enter     = (state == sm_idle) && (state_next == sm_run);
    assign running   = (state == sm_run) && run_reg;
    assign clear     = !running;
    assign h_step    = running && VID_CKE_IN;
    assign v_step    = h_step && h_at_last;
    assign frame_end = v_step && v_at_last;

    // Shadow config: captured on start and at every frame wrap, so changes land on frame boundaries.
    always_ff @(posedge VID_CLK_IN or posedge VID_RST_IN) begin
        if (VID_RST_IN) begin
            shadow <= '0;
        end else if (enter || frame_end) begin
            shadow <= cfg_in;
        end
    end

    prt_vtb_tg_axis #(.P_CNT(P_CNT)) u_h_axis (
        .reset     (VID_RST_IN),
        .clock     (VID_CLK_IN),
        .clear     (clear),
        .step      (h_step),
        .total     (shadow.htotal),
        .sw        (shadow.hsw),
        .start     (shadow.hstart),
        .act       (shadow.hact),
        .at_last   (h_at_last),
        .sync_hit  (h_sync),
        .act_hit   (h_act),
        .start_hit (h_start)
    );

    prt_vtb_tg_axis #(.P_CNT(P_CNT)) u_v_axis (
        .reset     (VID_RST_IN),
        .clock     (VID_CLK_IN),
        .clear     (clear),
        .step      (v_step),
        .total     (shadow.vtotal),
        .sw        (shadow.vsw),
        .start     (shadow.vstart),
        .act       (shadow.vact),
        .at_last   (v_at_last),
        .sync_hit  (v_sync),
        .act_hit   (v_act),
        .start_hit (v_start)
    );

    // Output stage: decode of the current counters, one enabled clock behind them.
    always_ff @(posedge VID_CLK_IN or posedge VID_RST_IN) begin
        if (VID_RST_IN) begin
            hs_act <= 1'b0;
            vs_act <= 1'b0;
            de_q   <= 1'b0;
            sof_q  <= 1'b0;
        end else if (!running) begin
            hs_act <= 1'b0;
            vs_act <= 1'b0;
            de_q   <= 1'b0;
            sof_q  <= 1'b0;
        end else if (VID_CKE_IN) begin
            hs_act <= h_sync;
            vs_act <= v_sync;
            de_q   <= h_act && v_act;
            sof_q  <= h_act && v_act && h_start && v_start;
        end
    end

`ifdef PRT_VTB_TG_POL_EN
    // While idle the syncs follow the live polarity inputs so they rest at their inactive level.
    assign VID_HS_OUT = hs_act ^ ((state == sm_run) ? shadow.hs_pol : CFG_HS_POL_IN);
    assign VID_VS_OUT = vs_act ^ ((state == sm_run) ? shadow.vs_pol : CFG_VS_POL_IN);
`else
    assign VID_HS_OUT = hs_act;
    assign VID_VS_OUT = vs_act;
`endif
    assign VID_DE_OUT  = de_q;
    assign VID_SOF_OUT = sof_q;
    assign STA_RUN_OUT = (state == sm_run);

endmodule

// File: tb/tb_prt_vtb_tg.sv
// Directed testbench for prt_vtb_tg (default build, PRT_VTB_TG_POL_EN undefined).
module tb_prt_vtb_tg;

    logic        clk = 1'b0;
    logic        rst;
    logic        cke;
    logic        run;
    logic [15:0] cfg_htotal, cfg_hsw, cfg_hstart, cfg_hact;
    logic [15:0] cfg_vtotal, cfg_vsw, cfg_vstart, cfg_vact;
    logic        vs, hs, de, sof, sta;
    logic [3:0]  obs;

    int total_cnt = 0;
    int bad_cnt   = 0;

    int m_ht, m_hsw, m_hst, m_ha, m_vt, m_vsw, m_vst, m_va;

    prt_vtb_tg #(.P_PPC(2), .P_CNT(16)) dut (
        .VID_RST_IN    (rst),
        .VID_CLK_IN    (clk),
        .VID_CKE_IN    (cke),
        .CTL_RUN_IN    (run),
        .CFG_HTOTAL_IN (cfg_htotal),
        .CFG_HSW_IN    (cfg_hsw),
        .CFG_HSTART_IN (cfg_hstart),
        .CFG_HACT_IN   (cfg_hact),
        .CFG_VTOTAL_IN (cfg_vtotal),
        .CFG_VSW_IN    (cfg_vsw),
        .CFG_VSTART_IN (cfg_vstart),
        .CFG_VACT_IN   (cfg_vact),
        .VID_VS_OUT    (vs),
        .VID_HS_OUT    (hs),
        .VID_DE_OUT    (de),
        .VID_SOF_OUT   (sof),
        .STA_RUN_OUT   (sta)
    );

    always #5 clk = ~clk;

    assign obs = {vs, hs, de, sof};

    // Raster reference: {vs,hs,de,sof} for the k-th enabled clock after start.
    function automatic logic [3:0] exp_vec(int k);
        int ht, vt, h, v;
        logic e_hs, e_vs, e_de, e_sof;
        ht    = (m_ht < 2) ? 1 : m_ht;
        vt    = (m_vt < 2) ? 1 : m_vt;
        h     = k % ht;
        v     = (k / ht) % vt;
        e_hs  = (h < m_hsw);
        e_vs  = (v < m_vsw);
        e_de  = (h >= m_hst) && (h < m_hst + m_ha) && (v >= m_vst) && (v < m_vst + m_va);
        e_sof = e_de && (h == m_hst) && (v == m_vst);
        return {e_vs, e_hs, e_de, e_sof};
    endfunction

    task automatic set_cfg(input int ht, input int hw, input int hst, input int ha,
                           input int vt, input int vw, input int vst, input int va);
        cfg_htotal = 16'(ht); cfg_hsw = 16'(hw); cfg_hstart = 16'(hst); cfg_hact = 16'(ha);
        cfg_vtotal = 16'(vt); cfg_vsw = 16'(vw); cfg_vstart = 16'(vst); cfg_vact = 16'(va);
        m_ht = ht; m_hsw = hw; m_hst = hst; m_ha = ha;
        m_vt = vt; m_vsw = vw; m_vst = vst; m_va = va;
    endtask

    task automatic start_run(output bit ok);
        @(negedge clk);
        run = 1'b1;
        ok  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sta === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic stop_run();
        @(negedge clk);
        run = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; cke = 1'b1;
        set_cfg(10, 2, 3, 4, 6, 1, 2, 3);
        repeat (3) @(negedge clk);
        total_cnt++;
        if (obs !== 4'b0000 || sta !== 1'b0) begin
            bad_cnt++;
            $display("[TB] FAIL reset_idle got=%b sta=%b exp=0000 sta=0", obs, sta);
        end
        run = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (obs !== 4'b0000 || sta !== 1'b0) begin
            bad_cnt++;
            $display("[TB] FAIL reset_run_held got=%b sta=%b exp=0000 sta=0", obs, sta);
        end
        run = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (obs !== 4'b0000 || sta !== 1'b0) begin
            bad_cnt++;
            $display("[TB] FAIL reset_release got=%b sta=%b exp=0000 sta=0", obs, sta);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int de_n = 0, sof_n = 0, vs_n = 0;
        set_cfg(10, 2, 3, 4, 6, 1, 2, 3);
        start_run(ok);
        total_cnt++;
        if (!ok) begin bad_cnt++; $display("[TB] FAIL basic_start sta never rose"); end
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            total_cnt++;
            if (obs !== exp_vec(k)) begin
                bad_cnt++;
                $display("[TB] FAIL basic k=%0d got=%b exp=%b", k, obs, exp_vec(k));
            end
            de_n += int'(de); sof_n += int'(sof); vs_n += int'(vs);
        end
        total_cnt++;
        if (de_n != 24 || sof_n != 2 || vs_n != 20) begin
            bad_cnt++;
            $display("[TB] FAIL basic_counts de=%0d sof=%0d vs=%0d exp de=24 sof=2 vs=20", de_n, sof_n, vs_n);
        end
        stop_run();
    endtask

    task automatic test_cke();
        bit ok;
        int sof_n = 0;
        set_cfg(10, 2, 3, 4, 6, 1, 2, 3);
        start_run(ok);
        total_cnt++;
        if (!ok) begin bad_cnt++; $display("[TB] FAIL cke_start sta never rose"); end
        for (int j = 0; j < 240; j++) begin
            cke = (j % 2 == 0);
            @(negedge clk);
            total_cnt++;
            if (obs !== exp_vec(j / 2)) begin
                bad_cnt++;
                $display("[TB] FAIL cke j=%0d got=%b exp=%b", j, obs, exp_vec(j / 2));
            end
            sof_n += int'(sof);
        end
        total_cnt++;
        if (sof_n != 4) begin
            bad_cnt++;
            $display("[TB] FAIL cke_sof_samples got=%0d exp=4", sof_n);
        end
        cke = 1'b1;
        stop_run();
    endtask

    task automatic test_cfg_change();
        bit ok;
        int de0 = 0, de1 = 0;
        set_cfg(10, 2, 3, 4, 6, 1, 2, 3);
        start_run(ok);
        total_cnt++;
        if (!ok) begin bad_cnt++; $display("[TB] FAIL cfg_start sta never rose"); end
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            total_cnt++;
            if (obs !== exp_vec(k)) begin
                bad_cnt++;
                $display("[TB] FAIL cfg_change k=%0d got=%b exp=%b", k, obs, exp_vec(k));
            end
            if (k < 60) de0 += int'(de); else de1 += int'(de);
            if (k == 30) cfg_hact = 16'd6;
            if (k == 59) m_ha = 6;
        end
        total_cnt++;
        if (de0 != 12 || de1 != 18) begin
            bad_cnt++;
            $display("[TB] FAIL cfg_change_de frame0=%0d frame1=%0d exp 12 18", de0, de1);
        end
        stop_run();
    endtask

    task automatic test_run_stop();
        bit ok;
        set_cfg(10, 2, 3, 4, 6, 1, 2, 3);
        start_run(ok);
        total_cnt++;
        if (!ok) begin bad_cnt++; $display("[TB] FAIL stop_start sta never rose"); end
        for (int k = 0; k < 35; k++) @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (obs !== 4'b0010 || sta !== 1'b1) begin
            bad_cnt++;
            $display("[TB] FAIL stop_plus1 got=%b sta=%b exp=0010 sta=1", obs, sta);
        end
        @(negedge clk);
        total_cnt++;
        if (obs !== 4'b0000 || sta !== 1'b0) begin
            bad_cnt++;
            $display("[TB] FAIL stop_plus2 got=%b sta=%b exp=0000 sta=0", obs, sta);
        end
        run = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (obs !== 4'b0000 || sta !== 1'b0) begin
            bad_cnt++;
            $display("[TB] FAIL restart_plus1 got=%b sta=%b exp=0000 sta=0", obs, sta);
        end
        @(negedge clk);
        total_cnt++;
        if (obs !== 4'b0000 || sta !== 1'b1) begin
            bad_cnt++;
            $display("[TB] FAIL restart_plus2 got=%b sta=%b exp=0000 sta=1", obs, sta);
        end
        @(negedge clk);
        total_cnt++;
        if (obs !== 4'b1100) begin
            bad_cnt++;
            $display("[TB] FAIL restart_first got=%b exp=1100", obs);
        end
        stop_run();
    endtask

    task automatic test_reset_mid();
        bit ok;
        set_cfg(10, 2, 3, 4, 6, 1, 2, 3);
        start_run(ok);
        total_cnt++;
        if (!ok) begin bad_cnt++; $display("[TB] FAIL rstmid_start sta never rose"); end
        for (int k = 0; k < 21; k++) @(negedge clk);
        total_cnt++;
        if (obs !== 4'b0100) begin
            bad_cnt++;
            $display("[TB] FAIL rstmid_before got=%b exp=0100", obs);
        end
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (obs !== 4'b0000 || sta !== 1'b0) begin
            bad_cnt++;
            $display("[TB] FAIL rstmid_async got=%b sta=%b exp=0000 sta=0", obs, sta);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ok  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sta === 1'b1) begin ok = 1'b1; break; end
        end
        total_cnt++;
        if (!ok) begin bad_cnt++; $display("[TB] FAIL rstmid_restart sta never rose"); end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            total_cnt++;
            if (obs !== exp_vec(k)) begin
                bad_cnt++;
                $display("[TB] FAIL rstmid k=%0d got=%b exp=%b", k, obs, exp_vec(k));
            end
        end
        stop_run();
    endtask

    task automatic test_clip();
        bit ok;
        int de_n = 0, vs_n = 0;
        set_cfg(10, 2, 8, 5, 6, 0, 2, 3);
        start_run(ok);
        total_cnt++;
        if (!ok) begin bad_cnt++; $display("[TB] FAIL clip_start sta never rose"); end
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            total_cnt++;
            if (obs !== exp_vec(k)) begin
                bad_cnt++;
                $display("[TB] FAIL clip k=%0d got=%b exp=%b", k, obs, exp_vec(k));
            end
            de_n += int'(de); vs_n += int'(vs);
        end
        total_cnt++;
        if (de_n != 6 || vs_n != 0) begin
            bad_cnt++;
            $display("[TB] FAIL clip_counts de=%0d vs=%0d exp de=6 vs=0", de_n, vs_n);
        end
        stop_run();
    endtask

    task automatic test_degenerate();
        bit ok;
        int de_n = 0;
        set_cfg(0, 1, 0, 1, 4, 1, 1, 2);
        start_run(ok);
        total_cnt++;
        if (!ok) begin bad_cnt++; $display("[TB] FAIL degen_start sta never rose"); end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            total_cnt++;
            if (obs !== exp_vec(k)) begin
                bad_cnt++;
                $display("[TB] FAIL degen_htotal k=%0d got=%b exp=%b", k, obs, exp_vec(k));
            end
        end
        stop_run();
        set_cfg(10, 2, 3, 0, 6, 1, 2, 3);
        start_run(ok);
        total_cnt++;
        if (!ok) begin bad_cnt++; $display("[TB] FAIL degen_hact_start sta never rose"); end
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            de_n += int'(de) + int'(sof);
        end
        total_cnt++;
        if (de_n != 0) begin
            bad_cnt++;
            $display("[TB] FAIL degen_hact0 de_plus_sof=%0d exp=0", de_n);
        end
        stop_run();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_cke();
        test_cfg_change();
        test_run_stop();
        test_reset_mid();
        test_clip();
        test_degenerate();
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
